// File: rtl/spinn_pkt_arb.sv
// Round-robin arbiter merging NUM_IN packet requesters into one registered output for spinn_driver.
// Optional per-requester saturating grant counters are built when SPINN_ARB_STATS_EN is defined.
module spinn_pkt_arb #(
  parameter int NUM_IN = 4,
  parameter int PKT_W  = 72
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*PKT_W-1:0] in_pkt_data,
  input  logic [NUM_IN-1:0]       in_pkt_vld,
  output logic [NUM_IN-1:0]       in_pkt_rdy,
  input  logic [NUM_IN-1:0]       arb_en,
  output logic [PKT_W-1:0]        out_pkt_data,
  output logic                    out_pkt_vld,
  input  logic                    out_pkt_rdy,
  output logic [2:0]              out_src,
  input  logic [2:0]              stats_sel,
  output logic [15:0]             stats_cnt
);

  logic              free;
  logic              grant_hit;
  logic              grant_fire;
  logic [2:0]        grant_idx;
  logic [2:0]        last_grant;
  logic [NUM_IN-1:0] elig;
  logic [PKT_W-1:0]  grant_data;

  assign free       = ~out_pkt_vld | out_pkt_rdy;
  assign elig       = in_pkt_vld & arb_en;
  assign grant_fire = ~rst & free & grant_hit;

  // Cyclic search starting one past the last winner; first eligible hit wins.
  always_comb begin
    int unsigned j;
    j         = 0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      j = 32'(last_grant) + k;
      if (j >= 32'(NUM_IN)) j = j - 32'(NUM_IN);
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (i == j && elig[i] && !grant_hit) begin
          grant_hit = 1'b1;
          grant_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    in_pkt_rdy = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant_idx == 3'(i)) begin
        in_pkt_rdy[i] = grant_fire;
        grant_data    = in_pkt_data[i*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pkt_vld  <= 1'b0;
      out_pkt_data <= '0;
      out_src      <= '0;
      last_grant   <= 3'(NUM_IN - 1);
    end else if (free) begin
      if (grant_hit) begin
        out_pkt_vld  <= 1'b1;
        out_pkt_data <= grant_data;
        out_src      <= grant_idx;
        last_grant   <= grant_idx;
      end else begin
        out_pkt_vld <= 1'b0;
      end
    end
  end

`ifdef SPINN_ARB_STATS_EN
  logic [15:0] cnt [NUM_IN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else if (grant_fire) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (grant_idx == 3'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  // Selects beyond NUM_IN match no entry and read as zero.
  always_comb begin
    stats_cnt = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (stats_sel == 3'(i)) stats_cnt = cnt[i];
    end
  end
`else
  logic unused_stats_sel;
  assign unused_stats_sel = ^stats_sel;
  assign stats_cnt        = '0;
`endif

endmodule

// File: tb/tb_spinn_pkt_arb.sv
// Self-checking bench for spinn_pkt_arb: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_spinn_pkt_arb;
  localparam int N = 4;
  localparam int W = 72;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_pkt_data;
  logic [N-1:0]   in_pkt_vld, in_pkt_rdy, arb_en;
  logic [W-1:0]   out_pkt_data;
  logic           out_pkt_vld, out_pkt_rdy;
  logic [2:0]     out_src, stats_sel;
  logic [15:0]    stats_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  spinn_pkt_arb #(.NUM_IN(N), .PKT_W(W)) dut (
    .clk(clk), .rst(rst), .in_pkt_data(in_pkt_data), .in_pkt_vld(in_pkt_vld),
    .in_pkt_rdy(in_pkt_rdy), .arb_en(arb_en), .out_pkt_data(out_pkt_data),
    .out_pkt_vld(out_pkt_vld), .out_pkt_rdy(out_pkt_rdy), .out_src(out_src),
    .stats_sel(stats_sel), .stats_cnt(stats_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] en;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_vld;
    logic [2:0] exp_src;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int i);
    return {8'(i + 1), 32'hC0DE0000 + 32'(i), 32'(i) * 32'h01010101};
  endfunction

  task automatic load_pat();
    for (int i = 0; i < N; i++) in_pkt_data[i*W +: W] = pat(i);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_pkt_vld = '1; arb_en = '1; out_pkt_rdy = 1'b1; stats_sel = '0;
    load_pat();
    #1 chk("rdy_in_reset", W'(in_pkt_rdy), '0);
    @(posedge clk); #1;
    chk("rst_vld", W'(out_pkt_vld), '0);
    chk("rst_data", out_pkt_data, '0);
    chk("rst_src", W'(out_src), '0);
    chk("rst_stats", W'(stats_cnt), '0);
    rst = 1'b0; in_pkt_vld = '0;
  endtask

  // Reference model state
  bit               m_vld;
  logic [W-1:0]     m_data;
  int               m_src, m_lg;
  logic [W+2:0]     sb[$];

  function automatic int pick(input int lg, input logic [N-1:0] v, input logic [N-1:0] e);
    for (int k = 1; k <= N; k++) begin
      int i = (lg + k) % N;
      if (v[i] && e[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    vec_t tbl[$];
    int   cnt;
    bit   free;
    int   g;
    logic [W+2:0] item;

    // Table from reset (last grant = 3): round robin, masked rotation, stalls, idle.
    tbl.push_back('{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 3'd0});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 3'd1});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 3'd2});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 3'd3});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 3'd0});
    tbl.push_back('{4'hF, 4'hB, 1'b1, 4'b0010, 1'b1, 3'd1});
    tbl.push_back('{4'hF, 4'hB, 1'b1, 4'b1000, 1'b1, 3'd3});
    tbl.push_back('{4'hF, 4'hB, 1'b1, 4'b0001, 1'b1, 3'd0});
    tbl.push_back('{4'hF, 4'hB, 1'b1, 4'b0010, 1'b1, 3'd1});
    tbl.push_back('{4'hF, 4'hB, 1'b0, 4'b0000, 1'b1, 3'd1});
    tbl.push_back('{4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 3'd0});
    tbl.push_back('{4'h0, 4'hF, 1'b0, 4'b0000, 1'b0, 3'd0});
    tbl.push_back('{4'h4, 4'hF, 1'b0, 4'b0100, 1'b1, 3'd2});
    tbl.push_back('{4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 3'd2});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 3'd3});

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      in_pkt_vld = tbl[r].vld; arb_en = tbl[r].en; out_pkt_rdy = tbl[r].ordy;
      #1 chk($sformatf("tbl%0d_rdy", r), W'(in_pkt_rdy), W'(tbl[r].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_vld", r), W'(out_pkt_vld), W'(tbl[r].exp_vld));
      if (tbl[r].exp_vld) begin
        chk($sformatf("tbl%0d_src", r), W'(out_src), W'(tbl[r].exp_src));
        chk($sformatf("tbl%0d_data", r), out_pkt_data, pat(int'(tbl[r].exp_src)));
      end
    end

    // Single requester held under backpressure, then drained exactly once.
    do_reset();
    in_pkt_data = '0; in_pkt_data[2*W +: W] = 72'h0A5;
    in_pkt_vld = 4'b0100; arb_en = 4'hF; out_pkt_rdy = 1'b0;
    #1 chk("hold_grant_rdy", W'(in_pkt_rdy), W'(4'b0100));
    @(posedge clk); #1;
    chk("hold_src", W'(out_src), 2);
    for (int c = 0; c < 5; c++) begin
      #1 chk("hold_rdy0", W'(in_pkt_rdy), '0);
      @(posedge clk); #1;
      chk("hold_data", out_pkt_data, 72'h0A5);
      chk("hold_vld", W'(out_pkt_vld), 1);
    end
    in_pkt_vld = '0; out_pkt_rdy = 1'b1; cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (out_pkt_vld && out_pkt_rdy) cnt++;
      @(posedge clk);
    end
    #1 chk("hold_one_xfer", W'(cnt), 1);
    chk("hold_drained", W'(out_pkt_vld), 0);

    // Mask cleared while requester 1's packet is held.
    do_reset();
    in_pkt_vld = 4'b0010; arb_en = 4'hF; out_pkt_rdy = 1'b0;
    #1 chk("mask_grant_rdy", W'(in_pkt_rdy), W'(4'b0010));
    @(posedge clk); #1;
    arb_en = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      #1 chk("mask_stall_rdy", W'(in_pkt_rdy), '0);
      @(posedge clk); #1;
      chk("mask_held_src", W'(out_src), 1);
      chk("mask_held_vld", W'(out_pkt_vld), 1);
    end
    out_pkt_rdy = 1'b1; cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (out_pkt_vld && out_src == 3'd1) cnt++;
      if (c > 0) chk("mask_no_regrant", W'(in_pkt_rdy), '0);
      @(posedge clk);
    end
    #1 chk("mask_delivered_once", W'(cnt), 1);

    // Reset pulsed while a packet is held.
    do_reset();
    in_pkt_vld = 4'hF; arb_en = 4'hF; out_pkt_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_pkt_rdy = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pre_vld", W'(out_pkt_vld), 1);
    rst = 1'b1;
    #1 chk("midrst_rdy", W'(in_pkt_rdy), '0);
    @(posedge clk); #1;
    chk("midrst_vld", W'(out_pkt_vld), 0);
    rst = 1'b0; out_pkt_rdy = 1'b1;
    #1 chk("midrst_next_rdy", W'(in_pkt_rdy), W'(4'b0001));
    @(posedge clk); #1;
    chk("midrst_next_src", W'(out_src), 0);

    // Statistics counters.
    do_reset();
    in_pkt_vld = 4'b0001; arb_en = 4'hF; out_pkt_rdy = 1'b1;
`ifdef SPINN_ARB_STATS_EN
    repeat (70000) @(posedge clk);
    #1 stats_sel = 3'd0;
    #1 chk("stats_sat", W'(stats_cnt), W'(16'hFFFF));
    stats_sel = 3'd5;
    #1 chk("stats_oob", W'(stats_cnt), '0);
    stats_sel = 3'd1;
    #1 chk("stats_other", W'(stats_cnt), '0);
`else
    repeat (20) @(posedge clk);
    #1 stats_sel = 3'd0;
    #1 chk("stats_tied0", W'(stats_cnt), '0);
    stats_sel = 3'd5;
    #1 chk("stats_oob", W'(stats_cnt), '0);
`endif
    stats_sel = '0;

    // Randomized run against the reference model and a transfer scoreboard.
    do_reset();
    m_vld = 0; m_lg = N - 1; m_src = 0; m_data = '0; sb.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) in_pkt_data[i*W +: W] = {8'($urandom), $urandom, $urandom};
      in_pkt_vld  = N'($urandom);
      arb_en      = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'($urandom) | N'($urandom);
      out_pkt_rdy = ($urandom_range(0, 3) != 0);
      #1;
      free = !m_vld || out_pkt_rdy;
      g = free ? pick(m_lg, in_pkt_vld, arb_en) : -1;
      chk("rnd_rdy", W'(in_pkt_rdy), (g >= 0) ? W'(1 << g) : '0);
      if (out_pkt_vld && out_pkt_rdy) begin
        if (sb.size() == 0) chk("rnd_sb_empty", 1, 0);
        else begin
          item = sb.pop_front();
          chk("rnd_sb_order", {out_src, out_pkt_data}, item);
        end
      end
      for (int i = 0; i < N; i++)
        if (in_pkt_vld[i] && in_pkt_rdy[i]) sb.push_back({3'(i), in_pkt_data[i*W +: W]});
      if (g >= 0) begin
        m_vld = 1; m_src = g; m_lg = g; m_data = in_pkt_data[g*W +: W];
      end else if (free) m_vld = 0;
      @(posedge clk); #1;
      chk("rnd_vld", W'(out_pkt_vld), W'(m_vld));
      if (m_vld) begin
        chk("rnd_src", W'(out_src), W'(m_src));
        chk("rnd_data", out_pkt_data, m_data);
      end
    end
    chk("rnd_sb_backlog", W'(sb.size()), W'(m_vld));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
